// File: rtl/vedic_mac_seq.sv
// rtl/vedic_mac_seq.sv - iterative 16x16 unsigned MAC time-sharing one vedic_4x4 multiplier

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // Urdhva-tiryagbhyam 2x2 cell: vertical and crosswise products
    function automatic logic [3:0] v2x2(input logic [1:0] x, input logic [1:0] y);
        logic s1, c1, m;
        s1 = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1 = (x[1] & y[0]) & (x[0] & y[1]);
        m  = x[1] & y[1];
        return {m & c1, m ^ c1, s1, x[0] & y[0]};
    endfunction

    logic [3:0] ll, hl, lh, hh;

    assign ll = v2x2(a[1:0], b[1:0]);
    assign hl = v2x2(a[3:2], b[1:0]);
    assign lh = v2x2(a[1:0], b[3:2]);
    assign hh = v2x2(a[3:2], b[3:2]);
    assign p  = {4'd0, ll} + {2'd0, hl, 2'd0} + {2'd0, lh, 2'd0} + {hh, 4'd0};
endmodule

module vedic_mac_seq #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic             acc_en,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      product,
    output logic [ACC_W-1:0] acc,
    output logic             overflow,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [15:0]      a_r, b_r;
    logic             acc_en_r;
    logic [3:0]       k;
    logic [31:0]      sum;
    logic [31:0]      product_r;
    logic [ACC_W-1:0] acc_r;
    logic             ovf_r;

    logic [3:0]       nib_a, nib_b;
    logic [7:0]       pp;
    logic [2:0]       ij;
    logic [4:0]       shamt;
    logic [31:0]      pp_sh;
    logic [ACC_W:0]   acc_sum;

    assign nib_a = a_r[{k[1:0], 2'b00} +: 4];
    assign nib_b = b_r[{k[3:2], 2'b00} +: 4];

    vedic_4x4 u_mul (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    // Weight of partial product (i, j) is 16^(i+j)
    assign ij      = {1'b0, k[1:0]} + {1'b0, k[3:2]};
    assign shamt   = {ij, 2'b00};
    assign pp_sh   = {24'd0, pp} << shamt;
    assign acc_sum = {1'b0, acc_r} + (ACC_W+1)'(sum);

    assign in_ready  = rst_n && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign product   = product_r;
    assign acc       = acc_r;
    assign overflow  = ovf_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc_en_r  <= 1'b0;
            k         <= '0;
            sum       <= '0;
            product_r <= '0;
            acc_r     <= '0;
            ovf_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_acc) begin
                        acc_r <= '0;
                        ovf_r <= 1'b0;
                    end
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        acc_en_r <= acc_en;
                        sum      <= '0;
                        k        <= '0;
                        state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    sum <= sum + pp_sh;
                    k   <= k + 4'd1;
                    if (k == 4'd15)
                        state <= S_ACC;
                end
                S_ACC: begin
                    product_r <= sum;
                    if (acc_en_r) begin
                        acc_r <= acc_sum[ACC_W-1:0];
                        ovf_r <= ovf_r | acc_sum[ACC_W];
                    end
                    state <= S_DONE;
                end
                default: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_mac_seq.sv
// tb/tb_vedic_mac_seq.sv - randomized self-checking bench for vedic_mac_seq (ACC_W=40 and 32)

module tb_vedic_mac_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, acc_en, clr_acc, out_ready;
    logic [15:0] a, b;
    logic        in_ready0, out_valid0, overflow0, busy0;
    logic        in_ready1, out_valid1, overflow1, busy1;
    logic [31:0] product0, product1;
    logic [39:0] acc0;
    logic [31:0] acc1;

    int tests = 0;
    int fails = 0;

    // reference state: plain integer arithmetic per accumulator width
    longint unsigned m_prod, m_acc40, m_acc32;
    bit              m_ovf40, m_ovf32;

    always #5 clk = ~clk;

    vedic_mac_seq #(.ACC_W(40)) u_dut40 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .acc_en(acc_en), .clr_acc(clr_acc),
        .out_valid(out_valid0), .out_ready(out_ready), .product(product0),
        .acc(acc0), .overflow(overflow0), .busy(busy0)
    );

    vedic_mac_seq #(.ACC_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .acc_en(acc_en), .clr_acc(clr_acc),
        .out_valid(out_valid1), .out_ready(out_ready), .product(product1),
        .acc(acc1), .overflow(overflow1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc40 = 0; m_ovf40 = 0;
        m_acc32 = 0; m_ovf32 = 0;
    endtask

    task automatic model_op(input logic [15:0] x, input logic [15:0] y, input bit en);
        m_prod = longint'(x) * longint'(y);
        if (en) begin
            m_acc40 = m_acc40 + m_prod;
            if (m_acc40 >= (64'd1 << 40)) begin m_acc40 -= (64'd1 << 40); m_ovf40 = 1; end
            m_acc32 = m_acc32 + m_prod;
            if (m_acc32 >= (64'd1 << 32)) begin m_acc32 -= (64'd1 << 32); m_ovf32 = 1; end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".prod40"}, 64'(product0), m_prod);
        check({tag, ".acc40"},  64'(acc0),     m_acc40);
        check({tag, ".ovf40"},  64'(overflow0), 64'(m_ovf40));
        check({tag, ".prod32"}, 64'(product1), m_prod);
        check({tag, ".acc32"},  64'(acc1),     m_acc32);
        check({tag, ".ovf32"},  64'(overflow1), 64'(m_ovf32));
    endtask

    // Called just after a negedge; returns after the cycle where IDLE is re-entered.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input bit en,
                         input bit clr, input int hold);
        int cnt;
        int guard;
        guard = 0;
        while (!in_ready0 && guard < 50) begin @(negedge clk); guard++; end
        check("op.in_ready", 64'(in_ready0), 64'd1);
        a = x; b = y; acc_en = en; clr_acc = clr; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clr_acc = 1'b0;
        a = 16'($urandom); b = 16'($urandom); acc_en = 1'($urandom);
        if (clr) model_clear();
        model_op(x, y, en);
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (!out_valid0 && cnt < 40);
        check("op.latency", 64'(cnt), 64'd17);
        check("op.ov32", 64'(out_valid1), 64'd1);
        check_outputs("op");
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; clr_acc = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            check("hold.out_valid", 64'(out_valid0), 64'd1);
            check("hold.in_ready", 64'(in_ready0), 64'd0);
            check("hold.product", 64'(product0), m_prod);
            check("hold.acc", 64'(acc0), m_acc40);
        end
        in_valid = 1'b0; clr_acc = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("rel.out_valid", 64'(out_valid0), 64'd0);
        check("rel.in_ready", 64'(in_ready0), 64'd1);
        check("rel.busy", 64'(busy0), 64'd0);
    endtask

    task automatic idle_clear();
        clr_acc = 1'b1;
        @(posedge clk);
        #1;
        clr_acc = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; acc_en = 1'b0; clr_acc = 1'b0;
        out_ready = 1'b0; a = '0; b = '0;
        m_prod = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready0), 64'd0);
        check("rst.out_valid", 64'(out_valid0), 64'd0);
        check("rst.busy", 64'(busy0), 64'd0);
        check_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.rel_in_ready", 64'(in_ready0), 64'd1);

        do_op(16'h0003, 16'h0005, 1'b0, 1'b0, 0);
        check("small.product", 64'(product0), 64'h0F);
        check("small.acc", 64'(acc0), 64'h0);

        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        check("max1.acc40", 64'(acc0), 64'h00FFFE0001);
        check("max1.acc32", 64'(acc1), 64'hFFFE0001);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        check("max2.acc32", 64'(acc1), 64'hFFFC0002);
        check("max2.ovf32", 64'(overflow1), 64'd1);
        check("max2.ovf40", 64'(overflow0), 64'd0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        check("max4.acc40", 64'(acc0), 64'h03FFF80004);

        idle_clear();
        check_outputs("clr");

        do_op(16'h00A5, 16'h0101, 1'b0, 1'b0, 10);

        // reset while the multiplier is at step k=7
        a = 16'h1234; b = 16'h5678; acc_en = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        m_prod = 0;
        model_clear();
        check("midrst.busy", 64'(busy0), 64'd0);
        check("midrst.in_ready", 64'(in_ready0), 64'd1);
        check("midrst.out_valid", 64'(out_valid0), 64'd0);
        check_outputs("midrst");
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
        check("post_rst.product", 64'(product0), 64'h06260060);

        do_op(16'h0055, 16'h0001, 1'b1, 1'b0, 0);
        check("pre_clr.acc", 64'(acc0), 64'h55);
        do_op(16'h0010, 16'h0010, 1'b1, 1'b1, 0);
        check("clr_hs.acc", 64'(acc0), 64'h100);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            if (n % 4 == 0) x = 16'hFFFF - 16'($urandom_range(0, 3));
            do_op(x, y, 1'($urandom), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) begin
                idle_clear();
                check_outputs("rnd_clr");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
